// File: rtl/dmem_pkg.sv
// Shared types and default widths for the data-memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int unsigned DMEM_AW = 8;
  localparam int unsigned DMEM_DW = 8;

endpackage

// File: rtl/dmem_timeout.sv
// ACCESS-cycle counter for the controller; expired_o flags the last allowed cycle.
module dmem_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the TIMEOUT-th ACCESS cycle so the FSM leaves on that edge.
  assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: CPU load/store handshake to a req/ack memory port.
// Optional access timeout is built when DMEM_CTRL_TIMEOUT_EN is defined.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int AW      = DMEM_AW,
  parameter int DW      = DMEM_DW,
  parameter int TIMEOUT = 16
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          read_mem,
  input  logic          write_mem,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          busywait,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          err
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("dmem_ctrl: TIMEOUT must lie in 2..255");
  end

  state_e        state_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;
  logic          busy_s;
  logic          expired_s;

`ifdef DMEM_CTRL_TIMEOUT_EN
  dmem_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i     (CLK),
    .rst_ni    (RESET_N),
    .en_i      (state_q == ACCESS),
    .clr_i     (state_q != ACCESS),
    .expired_o (expired_s)
  );
`else
  assign expired_s = 1'b0;
`endif

  // Control FSM with registered memory-port outputs, load result and error flag.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      if (mem_ack && (state_q != ACCESS)) begin
        err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (read_mem || write_mem) begin
            state_q     <= ACCESS;
            mem_req_q   <= 1'b1;
            mem_we_q    <= write_mem;
            mem_addr_q  <= addr;
            mem_wdata_q <= wdata;
            // Conflicting request resolves as a store but is flagged.
            if (read_mem && write_mem) begin
              err_q <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            if (!mem_we_q) begin
              rdata_q <= mem_rdata;
            end
          end else if (expired_s) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            if (!mem_we_q) begin
              rdata_q <= '0;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Stall: raised in the request cycle itself, dropped only in DONE.
  always_comb begin
    busy_s = 1'b0;
    case (state_q)
      IDLE:    busy_s = read_mem || write_mem;
      ACCESS:  busy_s = 1'b1;
      DONE:    busy_s = 1'b0;
      default: busy_s = 1'b0;
    endcase
  end

  assign busywait  = busy_s;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl (TIMEOUT=4).
module tb_dmem_ctrl;

  logic       CLK;
  logic       RESET_N;
  logic       read_mem;
  logic       write_mem;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busywait;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       err;

  int checks;
  int failures;

  dmem_ctrl #(
    .AW      (8),
    .DW      (8),
    .TIMEOUT (4)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .read_mem  (read_mem),
    .write_mem (write_mem),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .busywait  (busywait),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .err       (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    RESET_N   = 1'b0;
    read_mem  = 1'b0;
    write_mem = 1'b0;
    addr      = 8'h00;
    wdata     = 8'h00;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    #12;
    check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_rdata", {24'd0, rdata}, 32'h00);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    check_eq("rst_busy", {31'd0, busywait}, 32'd0);
    RESET_N = 1'b1;
    step();
    check_eq("idle_busy", {31'd0, busywait}, 32'd0);
    check_eq("idle_req", {31'd0, mem_req}, 32'd0);

    // Load 0x2A, ack on third ACCESS cycle.
    read_mem = 1'b1; addr = 8'h2A; #1;
    check_eq("ld_req_cycle_busy", {31'd0, busywait}, 32'd1);
    check_eq("ld_req_cycle_memreq", {31'd0, mem_req}, 32'd0);
    step();
    read_mem = 1'b0; addr = 8'hFF;
    check_eq("ld_a1_req", {31'd0, mem_req}, 32'd1);
    check_eq("ld_a1_we", {31'd0, mem_we}, 32'd0);
    check_eq("ld_a1_addr", {24'd0, mem_addr}, 32'h2A);
    check_eq("ld_a1_busy", {31'd0, busywait}, 32'd1);
    step();
    check_eq("ld_a2_busy", {31'd0, busywait}, 32'd1);
    check_eq("ld_a2_addr_stable", {24'd0, mem_addr}, 32'h2A);
    step();
    check_eq("ld_a3_busy", {31'd0, busywait}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 8'h5C;
    step();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    check_eq("ld_done_rdata", {24'd0, rdata}, 32'h5C);
    check_eq("ld_done_busy", {31'd0, busywait}, 32'd0);
    check_eq("ld_done_req", {31'd0, mem_req}, 32'd0);
    check_eq("ld_err", {31'd0, err}, 32'd0);
    step();

    // Store 0x10 <- 0xA5, ack on first ACCESS cycle.
    write_mem = 1'b1; addr = 8'h10; wdata = 8'hA5;
    step();
    write_mem = 1'b0; addr = 8'h00; wdata = 8'h00;
    check_eq("st_we", {31'd0, mem_we}, 32'd1);
    check_eq("st_addr", {24'd0, mem_addr}, 32'h10);
    check_eq("st_wdata", {24'd0, mem_wdata}, 32'hA5);
    check_eq("st_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 8'h77;
    step();
    mem_ack = 1'b0;
    check_eq("st_done_busy", {31'd0, busywait}, 32'd0);
    check_eq("st_rdata_kept", {24'd0, rdata}, 32'h5C);
    check_eq("st_err", {31'd0, err}, 32'd0);
    step();

    // Back-to-back loads; second request must wait out DONE.
    read_mem = 1'b1; addr = 8'h01;
    step();
    check_eq("b2b_a_addr", {24'd0, mem_addr}, 32'h01);
    mem_ack = 1'b1; mem_rdata = 8'h11;
    step();
    mem_ack = 1'b0; addr = 8'h02;
    check_eq("b2b_done_busy", {31'd0, busywait}, 32'd0);
    check_eq("b2b_done_rdata", {24'd0, rdata}, 32'h11);
    step();
    check_eq("b2b_idle_busy", {31'd0, busywait}, 32'd1);
    check_eq("b2b_idle_req", {31'd0, mem_req}, 32'd0);
    step();
    read_mem = 1'b0;
    check_eq("b2b_b_req", {31'd0, mem_req}, 32'd1);
    check_eq("b2b_b_addr", {24'd0, mem_addr}, 32'h02);
    mem_ack = 1'b1; mem_rdata = 8'h22;
    step();
    mem_ack = 1'b0;
    check_eq("b2b_b_rdata", {24'd0, rdata}, 32'h22);
    step();

    // Load with no ack.
    read_mem = 1'b1; addr = 8'h33;
    step();
    read_mem = 1'b0;
`ifdef DMEM_CTRL_TIMEOUT_EN
    step(); step(); step();
    check_eq("to_a4_busy", {31'd0, busywait}, 32'd1);
    step();
    check_eq("to_done_busy", {31'd0, busywait}, 32'd0);
    check_eq("to_rdata", {24'd0, rdata}, 32'h00);
    check_eq("to_err", {31'd0, err}, 32'd1);
    check_eq("to_req", {31'd0, mem_req}, 32'd0);
    step();
`else
    for (int i = 0; i < 20; i++) step();
    check_eq("noto_busy", {31'd0, busywait}, 32'd1);
    check_eq("noto_req", {31'd0, mem_req}, 32'd1);
    check_eq("noto_err", {31'd0, err}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 8'h44;
    step();
    mem_ack = 1'b0;
    check_eq("noto_rdata", {24'd0, rdata}, 32'h44);
    step();
`endif

    // Conflicting read+write resolves as a sticky-flagged store.
    RESET_N = 1'b0; #2; RESET_N = 1'b1;
    step();
    read_mem = 1'b1; write_mem = 1'b1; addr = 8'h03; wdata = 8'h9E;
    step();
    read_mem = 1'b0; write_mem = 1'b0;
    check_eq("both_we", {31'd0, mem_we}, 32'd1);
    check_eq("both_addr", {24'd0, mem_addr}, 32'h03);
    check_eq("both_err", {31'd0, err}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 8'h66;
    step();
    mem_ack = 1'b0;
    check_eq("both_rdata_kept", {24'd0, rdata}, 32'h00);
    step(); step();
    check_eq("both_err_sticky", {31'd0, err}, 32'd1);

    // Stray ack while idle.
    RESET_N = 1'b0; #2; RESET_N = 1'b1;
    step();
    check_eq("stray_pre_err", {31'd0, err}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    step();
    mem_ack = 1'b0;
    check_eq("stray_err", {31'd0, err}, 32'd1);
    check_eq("stray_rdata", {24'd0, rdata}, 32'h00);

    // Reset in the middle of an ACCESS.
    RESET_N = 1'b0; #2; RESET_N = 1'b1;
    step();
    read_mem = 1'b1; addr = 8'h55;
    step();
    read_mem = 1'b0;
    check_eq("mid_req_before", {31'd0, mem_req}, 32'd1);
    mem_rdata = 8'hBB;
    RESET_N = 1'b0; #1;
    check_eq("mid_req_drop", {31'd0, mem_req}, 32'd0);
    check_eq("mid_rdata", {24'd0, rdata}, 32'h00);
    check_eq("mid_err", {31'd0, err}, 32'd0);
    check_eq("mid_addr", {24'd0, mem_addr}, 32'h00);
    #2; RESET_N = 1'b1;
    step();
    check_eq("mid_post_busy", {31'd0, busywait}, 32'd0);
    check_eq("mid_post_req", {31'd0, mem_req}, 32'd0);
    check_eq("mid_post_rdata", {24'd0, rdata}, 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter AW, 8, address width.
REQ-002 SHALL have parameter DW, 8, data width.
REQ-003 SHALL have parameter TIMEOUT, 16, max cycles awaiting mem_ack (range 2..255).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: CLK input 1, rising-edge clock; RESET_N input 1, active-low reset.
REQ-005 SHALL have port read_mem input 1, CPU load request (from ControlUnit).
REQ-006 SHALL have port write_mem input 1, CPU store request.
REQ-007 SHALL have port addr input AW, CPU data address.
REQ-008 SHALL have port wdata input DW, CPU store data.
REQ-009 SHALL have port rdata output DW, load result to register file.
REQ-010 SHALL have port busywait output 1, stall PC/register write while high.
REQ-011 SHALL have ports mem_req, mem_we (outputs, 1), mem_addr (output, AW) and mem_wdata (output, DW) to the memory.
REQ-012 SHALL have ports mem_ack (input 1, one-cycle completion pulse) and mem_rdata (input DW).
REQ-013 SHALL have port err output 1, sticky error flag.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-015 IDLE: with read_mem|write_mem high, busywait SHALL be high combinationally in that same cycle; addr/wdata/op captured at the edge; next state ACCESS.
REQ-016 ACCESS: mem_req=1; mem_we/mem_addr/mem_wdata SHALL be driven from captured registers, stable until ack; busywait=1.
REQ-017 ACCESS + mem_ack: load SHALL latch mem_rdata into rdata; next state DONE; mem_req deasserts the following cycle.
REQ-018 DONE: busywait=0 for exactly one cycle (CPU commits); requests SHALL be ignored; next state IDLE.
REQ-019 Minimum load/store latency SHALL be 3 cycles request-to-busywait-low when mem_ack arrives on the first ACCESS cycle.
REQ-020 read_mem and write_mem both high: SHALL perform a write and set err.
REQ-021 mem_ack outside ACCESS SHALL be ignored and SHALL set err.
REQ-022 rdata SHALL hold its value until the next completed load; stores SHALL leave rdata unchanged.
REQ-023 Idle with no request: busywait=0, mem_req=0.

Reset
REQ-024 RESET_N low SHALL asynchronously force state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, err=0, timeout count=0.
REQ-025 Reset mid-ACCESS SHALL drop mem_req immediately; the aborted access SHALL NOT update rdata; busywait follows IDLE rule after release.

Configuration
REQ-026 DMEM_CTRL_TIMEOUT_EN defined: a counter SHALL increment each ACCESS cycle; reaching TIMEOUT without ack SHALL force rdata=0 (loads), set err, and go to DONE.
REQ-027 DMEM_CTRL_TIMEOUT_EN undefined: the counter SHALL be absent; ACCESS SHALL wait indefinitely for mem_ack.

Structure
REQ-028 A shared package dmem_pkg SHALL hold the state enum (IDLE/ACCESS/DONE) and default AW/DW constants.
REQ-029 The timeout counter SHALL be a sub-module dmem_timeout (enable, clear, expired), instantiated only under DMEM_CTRL_TIMEOUT_EN.

Verification
REQ-030 Load addr=0x2A, mem_ack on 3rd ACCESS cycle with mem_rdata=0x5C -> rdata=0x5C in DONE; busywait high 4 cycles then low 1.
REQ-031 Store addr=0x10 wdata=0xA5, ack on 1st ACCESS cycle -> mem_we=1, mem_wdata=0xA5, mem_addr=0x10; rdata unchanged; err=0.
REQ-032 read_mem=write_mem=1 addr=0x03 -> write performed (mem_we=1); err=1 and remains until reset.
REQ-033 RESET_N low during ACCESS -> mem_req=0 same cycle, state IDLE, rdata=0, err=0.
REQ-034 (TIMEOUT_EN, TIMEOUT=4) load with no ack -> DONE after 4 ACCESS cycles; rdata=0x00; err=1.
REQ-035 Back-to-back loads 0x01 then 0x02 -> exactly one DONE cycle between them; the second request is not sampled in DONE.
